cache_ctrl: RTL and testbench
=============================

CACHE_CTRL -- requirements
Module: cache_ctrl

Interface
REQ-001 The block SHALL have these parameters: DATA_W, default 32, word width; INDEX_W, default 5, line index width; TAG_W, default 6, tag width; WORDS_PER_BLOCK, default 8, words per line (OFFSET_W = 3); ADDR_W = TAG_W+INDEX_W+OFFSET_W (14), word address width.
REQ-002 The block SHALL have these ports, one per line, as name, direction, width, meaning:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request, sampled in IDLE only.
- cpu_we  in  1  1 = write, 0 = read.
- cpu_addr  in  ADDR_W  word address {tag, index, word}.
- cpu_wdata  in  DATA_W  write data.
- cpu_rdata  out  DATA_W  read data, valid while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write.
- mem_addr  out  ADDR_W  memory word address.
- mem_wdata  out  DATA_W  memory write data.
- mem_rdata  in  DATA_W  memory read data, valid with mem_ack.
- mem_ack  in  1  memory completes one word this cycle.
- index  out  INDEX_W  cache array line select.
- word_sel  out  3  cache array word select.
- we_data  out  1  cache array data write enable.
- we_tag  out  1  cache array tag write and valid-set enable.
- tag_in  out  TAG_W  tag to write.
- data_in  out  DATA_W  data to write.
- tag_out  in  TAG_W  stored tag, combinational read.
- valid_out  in  1  stored valid, combinational read.
- data_out  in  DATA_W  stored word, combinational read.
- hit_cnt  out  16  hits, saturating.
- miss_cnt  out  16  read misses, saturating.

Function
REQ-003 Cache policy SHALL be direct-mapped, write-through, no-write-allocate, with a full 8-word refill on a read miss.
REQ-004 FSM states SHALL be IDLE, LOOKUP, REFILL, WMEM, DONE.
REQ-005 IDLE: on cpu_req=1, latch cpu_addr, cpu_we and cpu_wdata, then go to LOOKUP. cpu_req in any other state SHALL be ignored.
REQ-006 LOOKUP: drive index and word_sel from the latched address. hit = valid_out and (tag_out == latched tag).
REQ-007 LOOKUP with read hit: register data_out into cpu_rdata, increment hit_cnt, go to DONE.
REQ-008 LOOKUP with write: if hit, assert we_data with data_in=wdata in that cycle and increment hit_cnt; in all cases go to WMEM.
REQ-009 LOOKUP with read miss: increment miss_cnt, clear the refill counter cnt, go to REFILL.
REQ-010 REFILL:
- mem_req=1, mem_we=0, mem_addr={tag,index,cnt}.
- On mem_ack: we_data=1, word_sel=cnt, data_in=mem_rdata.
- On mem_ack with cnt≠7: increment cnt.
- On mem_ack with cnt=7: also assert we_tag with tag_in=latched tag, then return to LOOKUP, which then hits.
- A re-lookup after refill SHALL NOT increment hit_cnt.
REQ-011 WMEM: mem_req=1, mem_we=1, mem_addr=latched address, mem_wdata=wdata; on mem_ack go to DONE.
REQ-012 DONE: cpu_ready=1 for exactly one cycle, then go to IDLE.
REQ-013 Write enables SHALL be combinational from state and mem_ack. we_data and we_tag SHALL be 0 outside the cases above.
REQ-014 mem_ack SHALL be ignored when mem_req=0. mem_req SHALL deassert in the cycle after mem_ack.
REQ-015 Latency with mem_ack returned in the same cycle as mem_req:
- Read hit: cpu_ready 2 cycles after the cpu_req sample edge.
- Write: 3 cycles.
- Read miss: 11 cycles.
REQ-016 Counters SHALL saturate at 16'hFFFF.

Reset
REQ-017 When rst=0 at a rising edge, the block SHALL enter IDLE, clear cnt, and drive cpu_ready, cpu_rdata, mem_req, mem_we, mem_addr, mem_wdata, we_data, we_tag, index, word_sel, tag_in, data_in, hit_cnt and miss_cnt to 0.
REQ-018 Reset mid-REFILL or mid-WMEM SHALL abort without a cpu_ready pulse or further array writes. The array SHALL share this reset (inverted to its active-high rst), so all valid bits clear and no partial line survives.

Verification
REQ-019 Read miss at cold start: cpu_addr=14'h2A1A (tag 101010, index 3, word 2), memory returns word k = 32'h1000_0000+k -> 8 mem reads at 14'h2A18..14'h2A1F, we_tag once with tag_in=6'b101010, cpu_rdata=32'h1000_0002, miss_cnt=1.
REQ-020 Read of 14'h2A1D right after REQ-019 -> no mem_req, cpu_rdata=32'h1000_0005, cpu_ready 2 cycles after request, hit_cnt=1.
REQ-021 Write 32'hDEADBEEF to 14'h2A1A (hit) -> we_data in LOOKUP, mem write to 14'h2A1A; a subsequent read returns 32'hDEADBEEF from the cache.
REQ-022 Write 32'hCAFEBABE to 14'h3C50 (miss, index 10) -> mem write only, no we_data or we_tag, miss_cnt unchanged.
REQ-023 Delayed mem_ack (3 wait cycles per word) -> mem_req and mem_addr stable while waiting; refill completes with correct data.
REQ-024 rst=0 asserted at the 4th refill word -> mem_req=0 next cycle, no cpu_ready; a re-read of the same address misses and refills all 8 words.

Source files
------------

// File: rtl/cache_ctrl.sv
// rtl/cache_ctrl.sv - direct-mapped write-through cache controller
// Drives an external tag/data array; read misses refill the whole line from memory.
module cache_ctrl #(
  parameter int DATA_W          = 32,
  parameter int INDEX_W         = 5,
  parameter int TAG_W           = 6,
  parameter int WORDS_PER_BLOCK = 8,
  localparam int OFFSET_W       = $clog2(WORDS_PER_BLOCK),
  localparam int ADDR_W         = TAG_W + INDEX_W + OFFSET_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                cpu_req,
  input  logic                cpu_we,
  input  logic [ADDR_W-1:0]   cpu_addr,
  input  logic [DATA_W-1:0]   cpu_wdata,
  output logic [DATA_W-1:0]   cpu_rdata,
  output logic                cpu_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic [INDEX_W-1:0]  index,
  output logic [OFFSET_W-1:0] word_sel,
  output logic                we_data,
  output logic                we_tag,
  output logic [TAG_W-1:0]    tag_in,
  output logic [DATA_W-1:0]   data_in,
  input  logic [TAG_W-1:0]    tag_out,
  input  logic                valid_out,
  input  logic [DATA_W-1:0]   data_out,
  output logic [15:0]         hit_cnt,
  output logic [15:0]         miss_cnt
);
  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] LOOKUP = 3'd1;
  localparam logic [2:0] REFILL = 3'd2;
  localparam logic [2:0] WMEM   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  logic [2:0]          state;
  logic [ADDR_W-1:0]   lat_addr;
  logic                lat_we;
  logic [DATA_W-1:0]   lat_wdata;
  logic [OFFSET_W-1:0] cnt;
  logic                refilled;
  logic [TAG_W-1:0]    lat_tag;
  logic [INDEX_W-1:0]  lat_index;
  logic [OFFSET_W-1:0] lat_word;
  logic                hit;
  logic                last_word;

  assign lat_tag   = lat_addr[ADDR_W-1 -: TAG_W];
  assign lat_index = lat_addr[OFFSET_W +: INDEX_W];
  assign lat_word  = lat_addr[OFFSET_W-1:0];
  assign hit       = valid_out && (tag_out == lat_tag);
  assign last_word = (cnt == OFFSET_W'(WORDS_PER_BLOCK - 1));

  // Array and memory strobes are pure decodes of state so a reset drops them at once.
  always_comb begin
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    index     = '0;
    word_sel  = '0;
    we_data   = 1'b0;
    we_tag    = 1'b0;
    tag_in    = '0;
    data_in   = '0;
    case (state)
      LOOKUP: begin
        index    = lat_index;
        word_sel = lat_word;
        data_in  = lat_wdata;
        we_data  = lat_we && hit;
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = {lat_tag, lat_index, cnt};
        index    = lat_index;
        word_sel = cnt;
        tag_in   = lat_tag;
        data_in  = mem_rdata;
        we_data  = mem_ack;
        we_tag   = mem_ack && last_word;
      end
      WMEM: begin
        mem_req   = 1'b1;
        mem_we    = 1'b1;
        mem_addr  = lat_addr;
        mem_wdata = lat_wdata;
      end
      DONE: cpu_ready = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      lat_addr  <= '0;
      lat_we    <= 1'b0;
      lat_wdata <= '0;
      cnt       <= '0;
      refilled  <= 1'b0;
      cpu_rdata <= '0;
      hit_cnt   <= '0;
      miss_cnt  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req) begin
            lat_addr  <= cpu_addr;
            lat_we    <= cpu_we;
            lat_wdata <= cpu_wdata;
            refilled  <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (lat_we) begin
            if (hit && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            state <= WMEM;
          end else if (hit) begin
            cpu_rdata <= data_out;
            // The re-lookup that follows a refill was already counted as a miss.
            if (!refilled && hit_cnt != 16'hFFFF) hit_cnt <= hit_cnt + 16'd1;
            state <= DONE;
          end else begin
            if (miss_cnt != 16'hFFFF) miss_cnt <= miss_cnt + 16'd1;
            cnt   <= '0;
            state <= REFILL;
          end
        end
        REFILL: begin
          if (mem_ack) begin
            if (last_word) begin
              refilled <= 1'b1;
              state    <= LOOKUP;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        WMEM: if (mem_ack) state <= DONE;
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_ctrl.sv
// tb/tb_cache_ctrl.sv - directed bench for cache_ctrl with array and memory models
module tb_cache_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we;
  logic [13:0] cpu_addr;
  logic [31:0] cpu_wdata, cpu_rdata;
  logic        cpu_ready;
  logic        mem_req, mem_we, mem_ack;
  logic [13:0] mem_addr;
  logic [31:0] mem_wdata, mem_rdata;
  logic [4:0]  index;
  logic [2:0]  word_sel;
  logic        we_data, we_tag;
  logic [5:0]  tag_in, tag_out;
  logic [31:0] data_in, data_out;
  logic        valid_out;
  logic [15:0] hit_cnt, miss_cnt;

  int vectors = 0;
  int miscompares = 0;

  cache_ctrl dut (
    .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
    .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata), .cpu_ready(cpu_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ack(mem_ack), .index(index), .word_sel(word_sel),
    .we_data(we_data), .we_tag(we_tag), .tag_in(tag_in), .data_in(data_in),
    .tag_out(tag_out), .valid_out(valid_out), .data_out(data_out),
    .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
  );

  always #5 clk = ~clk;

  // Cache array model, sharing the controller reset.
  logic        valid_arr [32];
  logic [5:0]  tag_arr   [32];
  logic [31:0] data_arr  [32][8];
  assign tag_out   = tag_arr[index];
  assign valid_out = valid_arr[index];
  assign data_out  = data_arr[index][word_sel];
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) valid_arr[i] <= 1'b0;
    end else begin
      if (we_data) data_arr[index][word_sel] <= data_in;
      if (we_tag) begin
        tag_arr[index]   <= tag_in;
        valid_arr[index] <= 1'b1;
      end
    end
  end

  // Memory model: word k of a line reads mem_base + k; ack after ack_delay wait cycles.
  logic [31:0] mem_base = 32'h1000_0000;
  int          ack_delay = 0;
  int          wait_ctr = 0;
  assign mem_rdata = mem_base + {29'b0, mem_addr[2:0]};
  assign mem_ack   = mem_req && (wait_ctr == ack_delay);
  always @(posedge clk) begin
    if (!mem_req || mem_ack) wait_ctr <= 0;
    else wait_ctr <= wait_ctr + 1;
  end

  int          rd_cnt = 0, wr_cnt = 0, req_cyc = 0;
  int          we_data_cnt = 0, we_tag_cnt = 0, ready_cnt = 0, stable_err = 0;
  logic [13:0] rd_log [64];
  logic [13:0] last_wr_addr = '0;
  logic [31:0] last_wr_data = '0;
  logic        prev_wait = 1'b0;
  logic [13:0] prev_addr = '0;
  always @(posedge clk) begin
    if (mem_req && mem_ack) begin
      if (mem_we) begin
        wr_cnt++;
        last_wr_addr = mem_addr;
        last_wr_data = mem_wdata;
      end else begin
        rd_log[rd_cnt % 64] = mem_addr;
        rd_cnt++;
      end
    end
    if (mem_req) req_cyc++;
    if (we_data) we_data_cnt++;
    if (we_tag) we_tag_cnt++;
    if (cpu_ready) ready_cnt++;
    if (prev_wait && mem_req && mem_addr !== prev_addr) stable_err++;
    prev_wait = mem_req && !mem_ack;
    prev_addr = mem_addr;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Issues one request and returns the cycle count from the sample edge to cpu_ready.
  task automatic access(input logic we, input logic [13:0] addr, input logic [31:0] wdata,
                        output int lat, output logic [31:0] rdata);
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    @(posedge clk); #1;
    cpu_req = 1'b0;
    lat = 1;
    while (!cpu_ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    rdata = cpu_rdata;
    @(posedge clk); #1;
    check("ready_one_cycle", {31'b0, cpu_ready}, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL global_timeout: observed no finish expected finish");
    $fatal(1);
  end

  int          lat, r0, w0, q0, d0, t0, c0;
  logic [31:0] rd;
  initial begin
    rst = 1'b0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cpu_ready", {31'b0, cpu_ready}, 32'd0);
    check("rst_mem_req", {31'b0, mem_req}, 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_we", {30'b0, we_data, we_tag}, 32'd0);
    check("rst_counts", {hit_cnt, miss_cnt}, 32'd0);
    check("rst_mem_addr", {18'b0, mem_addr}, 32'd0);
    @(negedge clk); rst = 1'b1;

    // Cold read miss with full line refill.
    r0 = rd_cnt; t0 = we_tag_cnt;
    access(1'b0, 14'h2A1A, 32'h0, lat, rd);
    check("miss_rdata", rd, 32'h1000_0002);
    check("miss_latency", lat, 32'd11);
    check("miss_mem_reads", rd_cnt - r0, 32'd8);
    for (int k = 0; k < 8; k++) check("miss_refill_addr", {18'b0, rd_log[(r0 + k) % 64]}, 32'h2A18 + k);
    check("miss_we_tag", we_tag_cnt - t0, 32'd1);
    check("miss_tag_stored", {26'b0, tag_arr[3]}, 32'h2A);
    check("miss_cnt_1", {16'b0, miss_cnt}, 32'd1);
    check("hit_cnt_after_refill", {16'b0, hit_cnt}, 32'd0);

    // Read hit on the refilled line.
    q0 = req_cyc;
    access(1'b0, 14'h2A1D, 32'h0, lat, rd);
    check("hit_rdata", rd, 32'h1000_0005);
    check("hit_latency", lat, 32'd2);
    check("hit_no_mem_req", req_cyc - q0, 32'd0);
    check("hit_cnt_1", {16'b0, hit_cnt}, 32'd1);

    // Write hit: array updated in LOOKUP and written through.
    w0 = wr_cnt; d0 = we_data_cnt; r0 = rd_cnt;
    access(1'b1, 14'h2A1A, 32'hDEADBEEF, lat, rd);
    check("whit_latency", lat, 32'd3);
    check("whit_mem_writes", wr_cnt - w0, 32'd1);
    check("whit_mem_addr", {18'b0, last_wr_addr}, 32'h2A1A);
    check("whit_mem_data", last_wr_data, 32'hDEADBEEF);
    check("whit_we_data", we_data_cnt - d0, 32'd1);
    check("whit_no_reads", rd_cnt - r0, 32'd0);
    check("hit_cnt_2", {16'b0, hit_cnt}, 32'd2);
    access(1'b0, 14'h2A1A, 32'h0, lat, rd);
    check("whit_readback", rd, 32'hDEADBEEF);
    check("whit_readback_lat", lat, 32'd2);
    check("hit_cnt_3", {16'b0, hit_cnt}, 32'd3);

    // Write miss: no allocate.
    w0 = wr_cnt; d0 = we_data_cnt; t0 = we_tag_cnt;
    access(1'b1, 14'h3C50, 32'hCAFEBABE, lat, rd);
    check("wmiss_latency", lat, 32'd3);
    check("wmiss_mem_writes", wr_cnt - w0, 32'd1);
    check("wmiss_mem_addr", {18'b0, last_wr_addr}, 32'h3C50);
    check("wmiss_mem_data", last_wr_data, 32'hCAFEBABE);
    check("wmiss_no_array_write", (we_data_cnt - d0) + (we_tag_cnt - t0), 32'd0);
    check("wmiss_miss_cnt", {16'b0, miss_cnt}, 32'd1);
    check("wmiss_hit_cnt", {16'b0, hit_cnt}, 32'd3);

    // Refill with three wait cycles per word.
    ack_delay = 3; mem_base = 32'h2000_0000; r0 = rd_cnt; c0 = stable_err;
    access(1'b0, 14'h0A45, 32'h0, lat, rd);
    check("slow_rdata", rd, 32'h2000_0005);
    check("slow_latency", lat, 32'd35);
    check("slow_mem_reads", rd_cnt - r0, 32'd8);
    check("slow_stable", stable_err - c0, 32'd0);
    check("slow_line_w0", data_arr[8][0], 32'h2000_0000);
    check("slow_line_w7", data_arr[8][7], 32'h2000_0007);
    check("slow_miss_cnt", {16'b0, miss_cnt}, 32'd2);
    ack_delay = 0;

    // Reset during the fourth refill word.
    mem_base = 32'h3000_0000; r0 = rd_cnt; c0 = ready_cnt;
    @(negedge clk);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 14'h1F73;
    @(negedge clk);
    cpu_req = 1'b0;
    for (int i = 0; i < 50 && (rd_cnt - r0) != 3; i++) @(negedge clk);
    check("abort_reached_word4", rd_cnt - r0, 32'd3);
    rst = 1'b0;
    @(posedge clk); #1;
    check("abort_mem_req", {31'b0, mem_req}, 32'd0);
    check("abort_counts", {hit_cnt, miss_cnt}, 32'd0);
    @(negedge clk); rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("abort_no_ready", ready_cnt - c0, 32'd0);
    check("abort_valid_clear", {31'b0, valid_arr[14]}, 32'd0);
    r0 = rd_cnt;
    access(1'b0, 14'h1F73, 32'h0, lat, rd);
    check("reread_rdata", rd, 32'h3000_0003);
    check("reread_latency", lat, 32'd11);
    check("reread_mem_reads", rd_cnt - r0, 32'd8);
    check("reread_miss_cnt", {16'b0, miss_cnt}, 32'd1);
    mem_base = 32'h1000_0000; r0 = rd_cnt;
    access(1'b0, 14'h2A1A, 32'h0, lat, rd);
    check("post_rst_old_line_miss", rd_cnt - r0, 32'd8);
    check("post_rst_rdata", rd, 32'h1000_0002);
    check("post_rst_miss_cnt", {16'b0, miss_cnt}, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
